clk_enable_manager: RTL and testbench

CLK_ENABLE_MANAGER -- requirements
Module: clk_enable_manager

---
 rtl/clk_mgr_pkg.sv | 18 +
 rtl/clk_en_div.sv | 60 ++++++
 rtl/clk_enable_manager.sv | 127 ++++++++++++
 tb/tb_clk_enable_manager.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_mgr_pkg.sv
// Shared definitions for the clock-enable manager: FSM state encoding and
// default parameter values used by clk_enable_manager and clk_en_div.
package clk_mgr_pkg;

  // Encoding is visible on the fsm_state output, so values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_SEQ       = 2'd2,
    ST_RUN       = 2'd3
  } fsm_state_t;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_DIV_W       = 8;
  localparam int DEF_LOCK_FILT   = 16;
  localparam int DEF_RST_STAGGER = 8;

endpackage

// File: rtl/clk_en_div.sv
// One clock-enable divider channel.
// Holds a shadow copy of the divide ratio N (captured on cfg_load) and a
// free-running counter that produces a one-cycle clk_en pulse every N+1
// cycles while run is high. N=0 gives a continuously high enable.
//
// Ports:
//   clk_100m_in  clock, rising edge
//   rst_n        asynchronous active-low reset
//   ratio        divide ratio to capture into the shadow register
//   cfg_load     one-cycle strobe: capture ratio, restart counter
//   run          channel may produce pulses (RUN, enabled, out of reset)
//   clk_en       single-cycle enable pulse
module clk_en_div
  import clk_mgr_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk_100m_in,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] ratio,
  input  logic             cfg_load,
  input  logic             run,
  output logic             clk_en
);

  logic [DIV_W-1:0] shadow;
  logic [DIV_W-1:0] cnt;
  logic             pulse_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: the shadow and counter are plain registers (not a memory), so they
  // take the asynchronous reset like any other flop.
  always_ff @(posedge clk_100m_in or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      cnt     <= '0;
      pulse_q <= 1'b0;
    end else if (cfg_load) begin
      // Load wins over a terminal count in the same cycle.
      shadow  <= ratio;
      cnt     <= '0;
      pulse_q <= 1'b0;
    end else if (!run) begin
      cnt     <= '0;
      pulse_q <= 1'b0;
    end else if (cnt == shadow) begin
      cnt     <= '0;
      pulse_q <= 1'b1;
    end else begin
      cnt     <= cnt + DIV_W'(1);
      pulse_q <= 1'b0;
    end
  end

  // NOTE: the registered pulse is gated by the current run condition so the
  // enable drops in the very cycle the FSM leaves RUN, not one cycle later.
  assign clk_en = pulse_q & run;

endmodule

// File: rtl/clk_enable_manager.sv
// Clock-enable manager.
// Synchronises and filters the PLL lock, then releases per-channel resets
// one after another with a fixed stagger, and finally runs NUM_CH divider
// channels producing single-cycle clock-enable pulses. Losing lock in SEQ or
// RUN drops everything back to WAIT_LOCK.
//
// Ports:
//   clk_100m_in     clock, rising edge
//   rst_n           asynchronous active-low reset
//   pll_locked_raw  asynchronous PLL lock, double-flop synchronised here
//   div_ratio       channel i ratio in bits [i*DIV_W +: DIV_W]
//   cfg_load        strobe capturing div_ratio into the channel shadows
//   ch_enable       per-channel run gate
//   clk_en          per-channel single-cycle enable pulses
//   ch_rst_n        per-channel active-low reset, released in sequence
//   locked          high only in RUN
//   fsm_state       IDLE=0, WAIT_LOCK=1, SEQ=2, RUN=3
module clk_enable_manager
  import clk_mgr_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int DIV_W       = DEF_DIV_W,
  parameter int LOCK_FILT   = DEF_LOCK_FILT,
  parameter int RST_STAGGER = DEF_RST_STAGGER
) (
  input  logic                    clk_100m_in,
  input  logic                    rst_n,
  input  logic                    pll_locked_raw,
  input  logic [NUM_CH*DIV_W-1:0] div_ratio,
  input  logic                    cfg_load,
  input  logic [NUM_CH-1:0]       ch_enable,
  output logic [NUM_CH-1:0]       clk_en,
  output logic [NUM_CH-1:0]       ch_rst_n,
  output logic                    locked,
  output logic [1:0]              fsm_state
);

  fsm_state_t        state;
  logic              lock_meta;
  logic              lock_sync;
  logic [7:0]        lock_cnt;
  logic [7:0]        stagger_cnt;
  logic [NUM_CH-1:0] ch_rst_q;
  logic              locked_q;
  logic [NUM_CH-1:0] ch_run;

  always_ff @(posedge clk_100m_in or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta   <= 1'b0;
      lock_sync   <= 1'b0;
      state       <= ST_IDLE;
      lock_cnt    <= '0;
      stagger_cnt <= '0;
      ch_rst_q    <= '0;
      locked_q    <= 1'b0;
    end else begin
      // NOTE: two-flop synchroniser; only lock_sync may be used by logic.
      lock_meta <= pll_locked_raw;
      lock_sync <= lock_meta;

      if ((state == ST_SEQ || state == ST_RUN) && !lock_sync) begin
        state       <= ST_WAIT_LOCK;
        lock_cnt    <= '0;
        stagger_cnt <= '0;
        ch_rst_q    <= '0;
        locked_q    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state    <= ST_WAIT_LOCK;
            lock_cnt <= '0;
          end
          ST_WAIT_LOCK: begin
            if (!lock_sync) begin
              lock_cnt <= '0;
            end else if (lock_cnt == 8'(LOCK_FILT - 1)) begin
              // Channel 0 comes out of reset on the first SEQ cycle.
              state       <= ST_SEQ;
              lock_cnt    <= '0;
              stagger_cnt <= '0;
              ch_rst_q    <= NUM_CH'(1);
            end else begin
              lock_cnt <= lock_cnt + 8'd1;
            end
          end
          ST_SEQ: begin
            if (&ch_rst_q) begin
              state    <= ST_RUN;
              locked_q <= 1'b1;
            end else if (stagger_cnt == 8'(RST_STAGGER - 1)) begin
              // Shift in a one: releases the next channel in order.
              stagger_cnt <= '0;
              ch_rst_q    <= (ch_rst_q << 1) | NUM_CH'(1);
            end else begin
              stagger_cnt <= stagger_cnt + 8'd1;
            end
          end
          ST_RUN: begin
            state <= ST_RUN;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign ch_run    = (state == ST_RUN) ? (ch_enable & ch_rst_q) : '0;
  assign ch_rst_n  = ch_rst_q;
  assign locked    = locked_q;
  assign fsm_state = state;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_en_div #(
      .DIV_W(DIV_W)
    ) u_div (
      .clk_100m_in(clk_100m_in),
      .rst_n      (rst_n),
      .ratio      (div_ratio[i*DIV_W +: DIV_W]),
      .cfg_load   (cfg_load),
      .run        (ch_run[i]),
      .clk_en     (clk_en[i])
    );
  end

endmodule

// File: tb/tb_clk_enable_manager.sv
// Directed bench for clk_enable_manager with default parameters
// (NUM_CH=4, DIV_W=8, LOCK_FILT=16, RST_STAGGER=8).
// Edge numbering: cyc counts rising edges after rst_n release; outputs are
// sampled 1 ns after each edge.
module tb_clk_enable_manager;

  logic        clk_100m_in;
  logic        rst_n;
  logic        pll_locked_raw;
  logic [31:0] div_ratio;
  logic        cfg_load;
  logic [3:0]  ch_enable;
  logic [3:0]  clk_en;
  logic [3:0]  ch_rst_n;
  logic        locked;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  clk_enable_manager dut (
    .clk_100m_in   (clk_100m_in),
    .rst_n         (rst_n),
    .pll_locked_raw(pll_locked_raw),
    .div_ratio     (div_ratio),
    .cfg_load      (cfg_load),
    .ch_enable     (ch_enable),
    .clk_en        (clk_en),
    .ch_rst_n      (ch_rst_n),
    .locked        (locked),
    .fsm_state     (fsm_state)
  );

  initial clk_100m_in = 1'b0;
  always #5 clk_100m_in = ~clk_100m_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk_100m_in);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic run_until_state(input logic [1:0] s, input int budget);
    int n = 0;
    while (fsm_state !== s && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic load(input logic [31:0] r);
    div_ratio = r;
    cfg_load  = 1'b1;
    step();
    cfg_load  = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk_100m_in);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  // Ratios {ch3,ch2,ch1,ch0}
  localparam logic [31:0] RATIOS_A = {8'd255, 8'd4, 8'd1, 8'd0};
  localparam logic [31:0] RATIOS_B = {8'd255, 8'd4, 8'd4, 8'd0};
  localparam logic [31:0] RATIOS_C = {8'd255, 8'd4, 8'd2, 8'd0};

  initial begin
    int pcnt  [4];
    int plast [4];
    int pfirst[4];
    int pbad  [4];
    int period[4];
    int k;
    int n;
    int c0;

    period = '{1, 2, 5, 256};
    rst_n          = 1'b0;
    pll_locked_raw = 1'b1;
    div_ratio      = '0;
    cfg_load       = 1'b0;
    ch_enable      = 4'b1110;

    // ---- reset values while rst_n is low
    #12;
    check("rst_clk_en", clk_en, 4'b0000);
    check("rst_ch_rst_n", ch_rst_n, 4'b0000);
    check("rst_locked", locked, 0);
    check("rst_state", fsm_state, 0);

    // ---- lock acquisition and staggered reset release (lock constant high)
    release_reset();
    check("idle_before_edge", fsm_state, 0);
    step();
    check("idle_to_wait", fsm_state, 1);
    load(RATIOS_A);                       // shadows only, outside RUN
    check("load_outside_run_state", fsm_state, 1);
    check("load_outside_run_clk_en", clk_en, 4'b0000);
    run_until_state(2'd2, 200);
    // 2 sync edges + 16 filter edges
    check("seq_entry_edge", cyc, 18);
    check("seq_entry_rst", ch_rst_n, 4'b0001);
    step_to(25);
    check("rst_before_ch1", ch_rst_n, 4'b0001);
    step_to(26);
    check("rst_ch1", ch_rst_n, 4'b0011);
    step_to(34);
    check("rst_ch2", ch_rst_n, 4'b0111);
    step_to(42);
    check("rst_ch3", ch_rst_n, 4'b1111);
    check("seq_still_state", fsm_state, 2);
    check("seq_locked_low", locked, 0);
    step_to(43);
    check("run_state", fsm_state, 3);
    check("run_locked", locked, 1);
    check("run_entry_clk_en", clk_en, 4'b0000);

    // ---- ch_enable gating; N=0 pulses on the next cycle once enabled
    step();
    check("ch0_disabled", clk_en[0], 0);
    ch_enable = 4'b1111;
    check("ch0_enable_same_cycle", clk_en[0], 0);
    step();
    check("ch0_next_cycle", clk_en[0], 1);

    // ---- periods 1,2,5,256 over 1024 cycles measured from a load edge
    load(RATIOS_A);
    k = cyc;
    check("load_no_pulse", clk_en, 4'b0000);
    for (int ch = 0; ch < 4; ch++) begin
      pcnt[ch] = 0; plast[ch] = -1; pfirst[ch] = -1; pbad[ch] = 0;
    end
    for (int t = 0; t < 1024; t++) begin
      step();
      for (int ch = 0; ch < 4; ch++) begin
        if (clk_en[ch]) begin
          pcnt[ch]++;
          if (plast[ch] < 0) pfirst[ch] = cyc - k;
          else if (cyc - plast[ch] != period[ch]) pbad[ch]++;
          plast[ch] = cyc;
        end
      end
    end
    check("ch0_first", pfirst[0], 1);
    check("ch1_first", pfirst[1], 2);
    check("ch2_first", pfirst[2], 5);
    check("ch3_first", pfirst[3], 256);
    check("ch0_count", pcnt[0], 1024);
    check("ch1_count", pcnt[1], 512);
    check("ch2_count", pcnt[2], 204);
    check("ch3_count", pcnt[3], 4);
    check("ch0_bad_period", pbad[0], 0);
    check("ch1_bad_period", pbad[1], 0);
    check("ch2_bad_period", pbad[2], 0);
    check("ch3_bad_period", pbad[3], 0);

    // ---- cfg_load coinciding with terminal count of ratio 4 suppresses pulse
    load(RATIOS_B);
    step(); step(); step(); step();       // counters for ratio 4 now at 4
    load(RATIOS_B);
    check("load_over_terminal", clk_en[2:1], 2'b00);

    // ---- ch1 ratio 4 -> 2 mid-count: next pulse exactly 3 edges later
    step(); step();                       // ch1 counter at 2
    load(RATIOS_C);
    check("ratio_change_no_pulse", clk_en[1], 0);
    n = 0;
    do begin step(); n++; end while (!clk_en[1] && n < 20);
    check("ratio2_first_pulse", n, 3);
    n = 0;
    do begin step(); n++; end while (!clk_en[1] && n < 20);
    check("ratio2_period", n, 3);

    // ---- lock loss in RUN: WAIT_LOCK after 2 sync edges + 1
    pll_locked_raw = 1'b0;
    c0 = cyc;
    step_to(c0 + 2);
    check("loss_sync_state", fsm_state, 3);
    check("loss_sync_rst", ch_rst_n, 4'b1111);
    step_to(c0 + 3);
    check("loss_state", fsm_state, 1);
    check("loss_rst", ch_rst_n, 4'b0000);
    check("loss_clk_en", clk_en, 4'b0000);
    check("loss_locked", locked, 0);

    // ---- one-cycle glitch at filter count 10 restarts the filter
    rst_n          = 1'b0;
    pll_locked_raw = 1'b1;
    #7;
    release_reset();
    step_to(10);
    pll_locked_raw = 1'b0;                // sampled low at edge 11 only
    step();
    pll_locked_raw = 1'b1;
    check("glitch_no_early_seq_18", fsm_state, 1);
    run_until_state(2'd2, 200);
    // filter cleared at edge 13, then 16 locked edges
    check("glitch_seq_entry_edge", cyc, 29);

    // ---- asynchronous reset mid-SEQ
    step_to(34);
    check("mid_seq_state", fsm_state, 2);
    rst_n = 1'b0;
    #2;                                   // no clock edge in between
    check("async_rst_state", fsm_state, 0);
    check("async_rst_ch_rst", ch_rst_n, 4'b0000);
    check("async_rst_locked", locked, 0);
    check("async_rst_clk_en", clk_en, 4'b0000);

    // ---- re-acquisition from a clean reset takes the full 18 edges again
    release_reset();
    run_until_state(2'd2, 200);
    check("reacquire_seq_edge", cyc, 18);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
